// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine: SPI-mode SD command/response engine.
// It generates sd_cclk, runs the CS-high power-up preamble, shifts out a
// 48-bit command frame and captures the R1 or R7/R3 response.
// Build macro SD_SPI_CRC7_EN: when defined, CRC7 is generated internally and
// cmd_crc is ignored. When it is not defined, cmd_crc is sent as supplied.
`timescale 1ns/1ps
module sd_spi_cmd_engine #(
  parameter int CLK_DIV_SLOW = 125,
  parameter int CLK_DIV_FAST = 2,
  parameter int INIT_CLOCKS  = 80,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        resp_long,
  input  logic        fast_clk,
  output logic        resp_valid,
  output logic        resp_timeout,
  output logic [39:0] resp_data,
  output logic        sd_cclk,
  output logic        sd_cmd,
  input  logic        sd_data0,
  output logic        sd_cs
);

  // state   | meaning
  // S_IDLE  | ready for a command or a preamble request
  // S_INIT  | power-up preamble, CS and MOSI high
  // S_SEND  | shifting out the 48-bit command frame
  // S_WAIT  | hunting for the response start bit (NCR)
  // S_RECV  | shifting in the remaining response bits
  // S_TRAIL | 8 trailing clocks with CS low (Nrc)
  // S_DONE  | clock stopped, response strobe
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SEND, S_WAIT, S_RECV, S_TRAIL, S_DONE
  } state_t;

  localparam int CW = $clog2(CLK_DIV_SLOW > CLK_DIV_FAST ? CLK_DIV_SLOW : CLK_DIV_FAST) + 1;
  localparam int BW = 10;
  localparam logic [BW-1:0] INIT_LAST  = BW'(INIT_CLOCKS);
  localparam logic [BW-1:0] SEND_LAST  = BW'(47);
  localparam logic [BW-1:0] WAIT_LAST  = BW'(RESP_TIMEOUT * 8 - 1);
  localparam logic [BW-1:0] TRAIL_LAST = BW'(8);

  state_t        state, state_nxt;
  logic [CW-1:0] div_cnt, div_val;
  logic [BW-1:0] bit_cnt, rx_len;
  logic [47:0]   tx_sh;
  logic [39:0]   rx_sh;
  logic          long_q, from_init, ready_q;
  logic          running, wrap, rise, fall, bit_step;
  logic [6:0]    crc_use;

`ifdef SD_SPI_CRC7_EN
  logic unused_cmd_crc;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign crc_use        = crc7({2'b01, cmd_index, cmd_arg});
  assign unused_cmd_crc = ^cmd_crc;
`else
  assign crc_use = cmd_crc;
`endif

  assign running  = (state != S_IDLE) && (state != S_DONE);
  assign wrap     = running && (div_cnt == div_val - CW'(1));
  assign rise     = wrap && !sd_cclk;
  assign fall     = wrap && sd_cclk;
  assign rx_len   = long_q ? BW'(40) : BW'(8);
  assign bit_step = ((state == S_SEND) && fall) ||
                    (((state == S_INIT) || (state == S_WAIT) ||
                      (state == S_RECV) || (state == S_TRAIL)) && rise);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; phase changes are tied to sd_cclk edges.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (init_start) state_nxt = S_INIT;
               else if (cmd_valid && ready_q) state_nxt = S_SEND;
      S_INIT:  if (fall && bit_cnt == INIT_LAST) state_nxt = S_DONE;
      S_SEND:  if (fall && bit_cnt == SEND_LAST) state_nxt = S_WAIT;
      S_WAIT:  if (rise) begin
                 if (!sd_data0) state_nxt = S_RECV;
                 else if (bit_cnt == WAIT_LAST) state_nxt = S_TRAIL;
               end
      S_RECV:  if (rise && (bit_cnt + BW'(1)) == rx_len) state_nxt = S_TRAIL;
      S_TRAIL: if (fall && bit_cnt == TRAIL_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pin and handshake outputs decoded from the current state.
  always_comb begin
    cmd_ready  = ready_q && (state == S_IDLE);
    sd_cs      = 1'b1;
    sd_cmd     = 1'b1;
    resp_valid = 1'b0;
    case (state)
      S_SEND:                  begin sd_cs = 1'b0; sd_cmd = tx_sh[47]; end
      S_WAIT, S_RECV, S_TRAIL: sd_cs = 1'b0;
      S_DONE:                  resp_valid = !from_init;
      default: ;
    endcase
  end

  // Clock divider, bit counter, shift registers and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      div_cnt      <= '0;
      div_val      <= CW'(CLK_DIV_SLOW);
      sd_cclk      <= 1'b0;
      bit_cnt      <= '0;
      tx_sh        <= '1;
      rx_sh        <= '0;
      long_q       <= 1'b0;
      from_init    <= 1'b0;
      resp_timeout <= 1'b0;
      resp_data    <= '0;
    end else begin
      ready_q <= (state_nxt == S_IDLE);

      if (!running) begin
        div_cnt <= '0;
        sd_cclk <= 1'b0;
      end else if (wrap) begin
        div_cnt <= '0;
        sd_cclk <= ~sd_cclk;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end

      // The start bit already counts as the first received bit.
      if (state != state_nxt) bit_cnt <= (state_nxt == S_RECV) ? BW'(1) : '0;
      else if (bit_step)      bit_cnt <= bit_cnt + BW'(1);

      // Divider is frozen for the whole operation.
      if (state == S_IDLE && state_nxt != S_IDLE) begin
        div_val   <= fast_clk ? CW'(CLK_DIV_FAST) : CW'(CLK_DIV_SLOW);
        from_init <= (state_nxt == S_INIT);
      end

      // The first frame bit is on MOSI half a period before the first rise.
      if (state == S_IDLE && state_nxt == S_SEND) begin
        tx_sh        <= {2'b01, cmd_index, cmd_arg, crc_use, 1'b1};
        long_q       <= resp_long;
        resp_timeout <= 1'b0;
      end else if (state == S_SEND && fall) begin
        tx_sh <= {tx_sh[46:0], 1'b1};
      end

      if (state == S_WAIT && rise && !sd_data0) rx_sh <= '0;
      else if (state == S_RECV && rise)         rx_sh <= {rx_sh[38:0], sd_data0};

      if (state == S_WAIT && state_nxt == S_TRAIL) begin
        resp_timeout <= 1'b1;
        resp_data    <= '1;
      end
      if (state == S_RECV && state_nxt == S_TRAIL)
        resp_data <= long_q ? {rx_sh[38:0], sd_data0} : {rx_sh[6:0], sd_data0, 32'h0};
    end
  end

endmodule
